// File: rtl/pps_discipline.sv
// Purpose: disciplines a clock-divider PPS generator from the external GPS 1PPS input.
// Latency: 3 cycles from the pin to the internal edge; all outputs registered, +1 cycle.
// Backpressure: none; a new terminal count waits in a one-deep pending slot for div_wrap.
//
// Ports:
//   clk_in        local oscillator clock, the only clock
//   rst           synchronous active-high reset
//   gps_pps       external 1PPS, asynchronous to clk_in
//   div_wrap      one-cycle pulse from the divider at count 0; updates are applied only here
//   counter_value terminal count driven to the divider (period = counter_value + 1)
//   locked        LOCK_N consecutive in-tolerance measurements seen
//   holdover      reference lost; counter_value frozen until the reference returns
//   meas_valid    one-cycle pulse per accepted measurement
//   last_period   most recent measurement, accepted or not
module pps_discipline #(
  parameter logic [23:0] NOMINAL = 24'd9_999_999,
  parameter logic [23:0] TOL     = 24'd1000,
  parameter logic [3:0]  LOCK_N  = 4'd4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        gps_pps,
  input  logic        div_wrap,
  output logic [23:0] counter_value,
  output logic        locked,
  output logic        holdover,
  output logic        meas_valid,
  output logic [23:0] last_period
);

  localparam logic [23:0] M_LO    = NOMINAL - TOL;
  localparam logic [23:0] M_HI    = NOMINAL + TOL;
  // First count that can no longer belong to an in-tolerance interval.
  localparam logic [23:0] TIMEOUT = NOMINAL + TOL + 24'd1;

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_TRACK    = 2'd1,
    ST_HOLDOVER = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic        pps_meta, pps_sync, pps_dly, pps_edge;
  logic [23:0] cnt;
  logic [3:0]  good_cnt, good_inc;
  logic        pend;
  logic [23:0] pend_val;
  logic        m_valid, timeout_hit;
  logic        take_meas, enter_hold, leave_hold;

  // Two-flop synchronizer followed by a registered rising-edge detect.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pps_meta <= 1'b0;
      pps_sync <= 1'b0;
      pps_dly  <= 1'b0;
      pps_edge <= 1'b0;
    end else begin
      pps_meta <= gps_pps;
      pps_sync <= pps_meta;
      pps_dly  <= pps_sync;
      pps_edge <= pps_sync & ~pps_dly;
    end
  end

  // Interval counter: its value in the edge cycle is (edge-to-edge cycles - 1),
  // which is directly a terminal count. Saturates so a lost reference cannot wrap.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt <= 24'd0;
    end else if (pps_edge) begin
      cnt <= 24'd0;
    end else if (cnt != 24'hFF_FFFF) begin
      cnt <= cnt + 24'd1;
    end
  end

  assign m_valid     = (cnt >= M_LO) && (cnt <= M_HI);
  assign timeout_hit = (cnt == TIMEOUT) && !pps_edge;
  assign good_inc    = (good_cnt >= LOCK_N) ? LOCK_N : good_cnt + 4'd1;

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst) state <= ST_ACQUIRE;
    else     state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACQUIRE:  if (pps_edge)    state_nxt = ST_TRACK;
      ST_TRACK:    if (timeout_hit) state_nxt = ST_HOLDOVER;
      ST_HOLDOVER: if (pps_edge)    state_nxt = ST_TRACK;
      default:                      state_nxt = ST_ACQUIRE;
    endcase
  end

  // FSM action decode. The edge leaving ACQUIRE or HOLDOVER only opens an interval.
  always_comb begin
    take_meas  = 1'b0;
    enter_hold = 1'b0;
    leave_hold = 1'b0;
    case (state)
      ST_TRACK: begin
        take_meas  = pps_edge;
        enter_hold = timeout_hit;
      end
      ST_HOLDOVER: leave_hold = pps_edge;
      default: ;
    endcase
  end

  // Measurement, lock and apply datapath.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      counter_value <= NOMINAL;
      locked        <= 1'b0;
      holdover      <= 1'b0;
      meas_valid    <= 1'b0;
      last_period   <= 24'd0;
      good_cnt      <= 4'd0;
      pend          <= 1'b0;
      pend_val      <= 24'd0;
    end else begin
      meas_valid <= 1'b0;

      // Apply uses the pending value from before this cycle; a measurement
      // landing in the same cycle re-arms pend below and waits for the next wrap.
      if (div_wrap && pend) begin
        counter_value <= pend_val;
        pend          <= 1'b0;
      end

      if (take_meas) begin
        last_period <= cnt;
        if (m_valid) begin
          meas_valid <= 1'b1;
          pend_val   <= cnt;
          pend       <= 1'b1;
          good_cnt   <= good_inc;
          if (good_inc == LOCK_N) locked <= 1'b1;
        end else begin
          good_cnt <= 4'd0;
          locked   <= 1'b0;
        end
      end

      // Losing the reference drops any pending value so the divider keeps its
      // last applied period through holdover.
      if (enter_hold) begin
        holdover <= 1'b1;
        locked   <= 1'b0;
        good_cnt <= 4'd0;
        pend     <= 1'b0;
      end

      if (leave_hold) holdover <= 1'b0;
    end
  end

endmodule

// File: doc/pps_discipline.md
# pps_discipline

Disciplining controller for the clock-divider PPS generator. It measures the local-oscillator cycle count between rising edges of the external GPS 1PPS input and validates each measurement against a tolerance window. Each accepted measurement is loaded into the divider's terminal-count input (`counter_value`) on a divider wrap boundary. It also reports lock status and holdover when the reference disappears.

## Interface
- `NOMINAL`, 24'd9_999_999: terminal count for an ideal 10 MHz oscillator. Divider period is `counter_value`+1.
- `TOL`, 24'd1000: accepted deviation of a measurement from `NOMINAL`. Constraint: `TOL` < `NOMINAL`, and `NOMINAL`+`TOL`+1 < 2^24.
- `LOCK_N`, 4: consecutive valid measurements required to assert `locked`. Range 1..15.
- `clk_in`, input, 1: the single clock (local oscillator).
- `rst`, input, 1: reset; synchronous, active-high.
- `gps_pps`, input, 1: external 1PPS, asynchronous to `clk_in`.
- `div_wrap`, input, 1: one-cycle pulse from the divider when its count is 0. Updates are applied only on this pulse.
- `counter_value`, output, 24: terminal count driven to the divider.
- `locked`, output, 1: reference tracked and stable.
- `holdover`, output, 1: reference lost; `counter_value` is frozen.
- `meas_valid`, output, 1: one-cycle pulse per accepted measurement.
- `last_period`, output, 24: most recent measurement M, valid or not.

## Operation
- **Input sync:** 2-FF synchronizer on `gps_pps`, then a registered rising-edge detect that produces internal `edge` (1 cycle).
- **Interval counter `cnt` (24b):**
  - Cleared to 0 in the `edge` cycle; otherwise increments.
  - Saturates at 24'hFFFFFF.
  - M = value of `cnt` in the `edge` cycle, i.e. (edge-to-edge cycles − 1), directly usable as a terminal count.
- **Validity:** M is valid iff `NOMINAL`−`TOL` ≤ M ≤ `NOMINAL`+`TOL`. Both bounds are inclusive unsigned compares; no subtraction of M.
- **FSM, states ACQUIRE / TRACK / HOLDOVER:**
  - **ACQUIRE** (reset state): the first `edge` only starts an interval and goes to TRACK. No measurement, no `last_period` update.
  - **TRACK**, on `edge`: `last_period`←M.
    - If M is valid: pulse `meas_valid`, `pend_val`←M, `pend`←1, `good_cnt`←min(`good_cnt`+1, `LOCK_N`).
    - If M is invalid: `good_cnt`←0 and `locked`←0.
    - `locked`←1 when `good_cnt` reaches `LOCK_N`.
  - **TRACK**, when `cnt` = `NOMINAL`+`TOL`+1 with no `edge` (timeout): go to HOLDOVER. Set `holdover`←1, `locked`←0, `good_cnt`←0, `pend`←0 (discard the pending value).
  - **HOLDOVER**, on `edge`: `holdover`←0, go to TRACK. This edge only restarts the interval; no measurement is taken.
- **Apply:** when `div_wrap`=1 and `pend`=1: `counter_value`←`pend_val`, `pend`←0.
- **New valid M while `pend`=1:** overwrites `pend_val`.
- **Same-cycle `div_wrap` and a valid `edge` in TRACK:** `counter_value`←old `pend_val`. `pend_val`←new M and `pend` stays 1; the new value applies at the next `div_wrap`.
- **Same-cycle timeout and `div_wrap` with `pend`=1:** the apply happens first, then `pend`←0.
- **`rst` at any point:** aborts everything and discards `pend` with no apply.

## Timing
- **Reset values:**
  - `counter_value`=`NOMINAL`
  - `locked`=0, `holdover`=0, `meas_valid`=0, `last_period`=0
  - `cnt`=0, `good_cnt`=0, `pend`=0, state ACQUIRE
  - synchronizer/edge registers=0
- **`gps_pps` rise to `edge`:** `edge` is asserted in the 3rd `clk_in` cycle after the first sampling edge that sees the pin high. The latency is identical per edge, so it cancels in M.
- **Registered outputs:** `meas_valid`, `last_period`, `locked` and `holdover` all change on the clock edge following the `edge`/timeout cycle.
- **`counter_value`:** changes on the clock edge following a qualifying `div_wrap` cycle.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **Polling:** `pend` is visible only internally. `counter_value` changes at most once per `div_wrap` pulse.

## Test plan
Bench parameters: `NOMINAL`=99, `TOL`=2, `LOCK_N`=3.
1. **Lock-in:** reset, then `edge` every 100 cycles, `div_wrap` every 100 cycles offset 37.
   - 1st edge: no `meas_valid`.
   - Edges 2–4: `meas_valid` pulses with `last_period`=99.
   - `locked`=1 after edge 4.
   - `counter_value` stays 99.
2. **Tracking within tolerance:** after lock, period becomes 102 cycles (M=101, valid).
   - `meas_valid`=1, `last_period`=101.
   - `counter_value` unchanged until the next `div_wrap`, then 101 one cycle later.
   - `locked` stays 1.
3. **Out of tolerance:** one period of 103 (M=102).
   - No `meas_valid`; `last_period`=102; `locked`→0; `counter_value` unchanged.
   - Three following valid periods re-assert `locked`.
4. **Loss/recovery:** stop edges after lock with a value pending.
   - `holdover`=1 and `locked`=0 on the cycle after `cnt`=102.
   - Pending value discarded: the next `div_wrap` leaves `counter_value` unchanged.
   - Resume edges: 1st edge clears `holdover` with no `meas_valid`; 2nd edge gives `meas_valid`.
5. **Collision:** pending value 100, then a valid `edge` with M=98 in the same cycle as `div_wrap`.
   - `counter_value`=100 after that cycle.
   - `counter_value`=98 after the next `div_wrap`.
6. **Reset mid-operation:** assert `rst` for 1 cycle while locked with a pending value.
   - All outputs return to reset values: `counter_value`=99.
   - The next `edge` produces no measurement.
